// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and types for the pipeline stall/flush controller.
// The FSM codes match the legacy define.v values so existing trace tools still decode them.
package pipe_hazard_ctrl_pkg;

   localparam logic [1:0] HZ_IDLE    = 2'd0;
   localparam logic [1:0] HZ_WAIT    = 2'd1;
   localparam logic [1:0] HZ_RELEASE = 2'd2;

   localparam int DRAM_LAT = 2;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic ex_mem_stall;
      logic mem_wb_bubble;
      logic if_id_flush;
      logic id_ex_flush;
   } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Combinational load-use hazard detector: a load in EX writes a register the ID instruction reads.
// Also instantiated by the forwarding logic, so it stays free of any controller state.
module load_use_detect
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd_addr,
   output logic       hazard
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_rs1_used && (id_rs1_addr == ex_rd_addr);
   assign rs2_match = id_rs2_used && (id_rs2_addr == ex_rd_addr);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign hazard = ex_mem_read && (ex_rd_addr != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: DRAM wait FSM, load-use bubbles, branch squash
// and a saturating count of PC-stall cycles.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_LAT = DRAM_LAT,
   parameter int CNT_W   = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_redirect,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   output logic        pc_stall,
   output logic        if_id_stall,
   output logic        id_ex_stall,
   output logic        ex_mem_stall,
   output logic        mem_wb_bubble,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        busy,
   output logic [15:0] stall_cnt
);

   localparam bit               LONG_MEM    = (MEM_LAT > 1);
   localparam logic [CNT_W-1:0] LOAD_VAL    = CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 1) : 0);
   localparam logic [CNT_W-1:0] LAST_WAIT   = CNT_W'(2);
   localparam logic [1:0]       FIRST_STATE = (MEM_LAT > 2) ? HZ_WAIT : HZ_RELEASE;

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_acc;
   logic             mem_stall;
   logic             load_use;
   hz_ctrl_t         ctrl;

   assign mem_acc = mem_mem_read | mem_mem_write;

   load_use_detect u_load_use (
      .id_rs1_addr (id_rs1_addr),
      .id_rs2_addr (id_rs2_addr),
      .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used),
      .ex_mem_read (ex_mem_read),
      .ex_rd_addr  (ex_rd_addr),
      .hazard      (load_use)
   );

   // The IDLE cycle that spots the access already stalls, so WAIT covers the
   // remaining MEM_LAT-2 cycles and leaves once the counter is down to its last step.
   always_comb begin
      next_state = state;
      mem_stall  = 1'b0;
      case (state)
         HZ_IDLE: begin
            if (mem_acc && LONG_MEM) begin
               mem_stall  = 1'b1;
               next_state = FIRST_STATE;
            end
         end
         HZ_WAIT: begin
            mem_stall = 1'b1;
            if (wait_cnt <= LAST_WAIT) begin
               next_state = HZ_RELEASE;
            end
         end
         HZ_RELEASE: next_state = HZ_IDLE;
         default:    next_state = HZ_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HZ_IDLE;
         wait_cnt <= '0;
      end else begin
         state <= next_state;
         if (state == HZ_IDLE && mem_stall) begin
            wait_cnt <= LOAD_VAL;
         end else if (state == HZ_WAIT) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
      end
   end

   // Memory hold outranks everything: a branch stuck in EX acts once the hold ends,
   // and a redirect outranks the load-use bubble because that hazard is on the wrong path.
   always_comb begin
      ctrl = '0;
      if (mem_stall) begin
         ctrl.pc_stall      = 1'b1;
         ctrl.if_id_stall   = 1'b1;
         ctrl.id_ex_stall   = 1'b1;
         ctrl.ex_mem_stall  = 1'b1;
         ctrl.mem_wb_bubble = 1'b1;
      end else if (ex_redirect) begin
         ctrl.if_id_flush = 1'b1;
         ctrl.id_ex_flush = 1'b1;
      end else if (load_use) begin
         ctrl.pc_stall    = 1'b1;
         ctrl.if_id_stall = 1'b1;
         ctrl.id_ex_flush = 1'b1;
      end
   end

   assign pc_stall      = ctrl.pc_stall;
   assign if_id_stall   = ctrl.if_id_stall;
   assign id_ex_stall   = ctrl.id_ex_stall;
   assign ex_mem_stall  = ctrl.ex_mem_stall;
   assign mem_wb_bubble = ctrl.mem_wb_bubble;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_ex_flush   = ctrl.id_ex_flush;
   assign busy          = (state != HZ_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (ctrl.pc_stall && stall_cnt != STALL_CNT_MAX) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl (MEM_LAT=3) against a cycle-level
// reference model built from remaining-wait and pending-release bookkeeping.
module tb_pipe_hazard_ctrl;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        id_rs1_used, id_rs2_used, ex_mem_read, ex_redirect;
   logic        mem_mem_read, mem_mem_write;
   logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble;
   logic        if_id_flush, id_ex_flush, busy;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;

   int wait_left;
   bit rel_pending;
   int exp_cnt;
   bit e_mstall, e_pc, e_ifid, e_idex_flush, e_ifid_flush, e_busy, e_trig;

   pipe_hazard_ctrl #(.MEM_LAT(LAT), .CNT_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_rs1_addr   (id_rs1_addr),
      .id_rs2_addr   (id_rs2_addr),
      .id_rs1_used   (id_rs1_used),
      .id_rs2_used   (id_rs2_used),
      .ex_mem_read   (ex_mem_read),
      .ex_rd_addr    (ex_rd_addr),
      .ex_redirect   (ex_redirect),
      .mem_mem_read  (mem_mem_read),
      .mem_mem_write (mem_mem_write),
      .pc_stall      (pc_stall),
      .if_id_stall   (if_id_stall),
      .id_ex_stall   (id_ex_stall),
      .ex_mem_stall  (ex_mem_stall),
      .mem_wb_bubble (mem_wb_bubble),
      .if_id_flush   (if_id_flush),
      .id_ex_flush   (id_ex_flush),
      .busy          (busy),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic exr, input logic [4:0] rd,
                                input logic redir, input logic mr, input logic mw);
      id_rs1_addr   = rs1;
      id_rs2_addr   = rs2;
      id_rs1_used   = u1;
      id_rs2_used   = u2;
      ex_mem_read   = exr;
      ex_rd_addr    = rd;
      ex_redirect   = redir;
      mem_mem_read  = mr;
      mem_mem_write = mw;
   endtask

   task automatic checkOutput(input string tag);
      chk({tag, ".pc_stall"},      {15'd0, pc_stall},      {15'd0, e_pc});
      chk({tag, ".if_id_stall"},   {15'd0, if_id_stall},   {15'd0, e_ifid});
      chk({tag, ".id_ex_stall"},   {15'd0, id_ex_stall},   {15'd0, e_mstall});
      chk({tag, ".ex_mem_stall"},  {15'd0, ex_mem_stall},  {15'd0, e_mstall});
      chk({tag, ".mem_wb_bubble"}, {15'd0, mem_wb_bubble}, {15'd0, e_mstall});
      chk({tag, ".if_id_flush"},   {15'd0, if_id_flush},   {15'd0, e_ifid_flush});
      chk({tag, ".id_ex_flush"},   {15'd0, id_ex_flush},   {15'd0, e_idex_flush});
      chk({tag, ".busy"},          {15'd0, busy},          {15'd0, e_busy});
      chk({tag, ".stall_cnt"},     stall_cnt,              exp_cnt[15:0]);
   endtask

   task automatic modelReset();
      wait_left   = 0;
      rel_pending = 0;
      exp_cnt     = 0;
   endtask

   // Called right after a negedge with inputs already applied; returns at the next negedge.
   task automatic stepCycle(input string tag, input bit do_check);
      bit idle, lu;
      #1;
      idle = (wait_left == 0) && !rel_pending;
      lu   = ex_mem_read && (ex_rd_addr != 0) &&
             ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
      e_trig       = idle && (mem_mem_read || mem_mem_write) && (LAT > 1);
      e_mstall     = e_trig || (wait_left > 0);
      e_pc         = e_mstall || (!ex_redirect && lu);
      e_ifid       = e_pc;
      e_ifid_flush = !e_mstall && ex_redirect;
      e_idex_flush = !e_mstall && (ex_redirect || lu);
      e_busy       = !idle;
      if (do_check) checkOutput(tag);
      if (e_pc && exp_cnt < 65535) exp_cnt++;
      if (e_trig) begin
         wait_left   = LAT - 2;
         rel_pending = 1;
      end else if (wait_left > 0) begin
         wait_left--;
      end else if (rel_pending) begin
         rel_pending = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      $display("[TB] start, MEM_LAT=%0d", LAT);
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      modelReset();
      #12;
      chk("reset.busy", {15'd0, busy}, 16'd0);
      chk("reset.pc_stall", {15'd0, pc_stall}, 16'd0);
      chk("reset.stall_cnt", stall_cnt, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle("post_reset", 1);

      // Single load in IDLE: two stall cycles, one release cycle, back to idle
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      stepCycle("t1_trig", 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) stepCycle("t1_tail", 1);
      chk("t1.stall_cnt_is_2", stall_cnt, 16'd2);

      // Load-use on rs2, then the same with rd=x0
      applyStimulus(0, 5, 0, 1, 1, 5, 0, 0, 0);
      stepCycle("t2_lu", 1);
      chk("t2.pc_stall_direct", {15'd0, dut.pc_stall}, 16'd1);
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
      stepCycle("t2_x0", 1);

      // Redirect beats load-use
      applyStimulus(0, 5, 0, 1, 1, 5, 1, 0, 0);
      stepCycle("t3_redir", 1);

      // Redirect held through a memory wait is honoured only in the release cycle
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
      stepCycle("t4_trig", 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      stepCycle("t4_wait", 1);
      stepCycle("t4_release", 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle("t4_idle", 1);

      // Back-to-back stores with the write held through release
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) stepCycle("t5_b2b", 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) stepCycle("t5_tail", 1);

      // Asynchronous reset in the middle of a wait
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      stepCycle("t6_trig", 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("t6.busy_before_reset", {15'd0, busy}, 16'd1);
      rst_n = 1'b0;
      #1;
      chk("t6.busy", {15'd0, busy}, 16'd0);
      chk("t6.ex_mem_stall", {15'd0, ex_mem_stall}, 16'd0);
      chk("t6.pc_stall", {15'd0, pc_stall}, 16'd0);
      chk("t6.stall_cnt", stall_cnt, 16'd0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      stepCycle("t6_after", 1);

      // Random traffic on a small register window so hazards are frequent
      for (int i = 0; i < 400; i++) begin
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 5) == 0));
         stepCycle("rand", 1);
      end

      // Saturation: a sustained load-use hazard pushes the counter to its ceiling
      applyStimulus(3, 0, 1, 0, 1, 3, 0, 0, 0);
      for (int i = 0; i < 65540; i++) stepCycle("sat_run", 0);
      for (int i = 0; i < 3; i++) stepCycle("sat_hold", 1);
      chk("sat.stall_cnt", stall_cnt, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
